// File: rtl/memory_stage.sv
// Memory-access stage: data RAM loads/stores, stack push/pop, and flag restore behind a 3-state access FSM.
// The optional load-forwarding register is built only when the MEM_LOAD_FWD_EN macro is defined.
module memory_stage #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [1:0]        i_stack_op,
  input  logic [15:0]       i_address,
  input  logic [15:0]       i_write_data,
  output logic [15:0]       o_read_data,
  output logic [2:0]        o_flags_restore,
  output logic              o_data_valid,
  output logic              o_stall,
  output logic [ADDR_W-1:0] o_sp,
  output logic              o_stack_err,
  output logic [15:0]       o_load_fwd_data,
  output logic              o_load_fwd_valid
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_STORE, OP_LOAD, OP_PUSH, OP_POP, OP_POPF} op_t;

  localparam logic [ADDR_W-1:0] SP_TOP = ADDR_W'(DEPTH - 1);

  state_t            r_state, w_next;
  op_t               r_op, w_op;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_data;
  logic [ADDR_W-1:0] r_sp;
  logic              r_err;
  logic [15:0]       r_rd;
  logic [2:0]        r_flags;
  logic [15:0]       r_mem [DEPTH];

  logic              w_req, w_access, w_pop, w_pop_ok, w_push_ok;
  logic [ADDR_W-1:0] w_sp_inc, w_rd_addr;
  logic [15:0]       w_ram_rd;
  logic              w_unused;

  assign w_unused = ^i_address[15:ADDR_W];

  assign w_req = i_mem_read | i_mem_write | (i_stack_op != 2'd0);

  // Only one operation runs per request: store beats load beats stack op.
  always_comb begin
    w_op = OP_NONE;
    if (i_mem_write)             w_op = OP_STORE;
    else if (i_mem_read)         w_op = OP_LOAD;
    else if (i_stack_op == 2'd1) w_op = OP_PUSH;
    else if (i_stack_op == 2'd2) w_op = OP_POP;
    else if (i_stack_op == 2'd3) w_op = OP_POPF;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BUSY:  if (r_cnt == 4'd0) w_next = S_DONE;
      default: w_next = w_req ? S_BUSY : S_IDLE;
    endcase
  end

  always_comb begin
    o_data_valid = (r_state == S_DONE);
    o_stall      = (r_state == S_BUSY) | ((r_state != S_BUSY) & w_req);
  end

  assign w_access  = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_pop     = (r_op == OP_POP) || (r_op == OP_POPF);
  assign w_pop_ok  = w_pop && (r_sp != SP_TOP);
  assign w_push_ok = (r_op == OP_PUSH) && (r_sp != '0);
  assign w_sp_inc  = r_sp + 1'b1;
  assign w_rd_addr = (r_op == OP_LOAD) ? r_addr : w_sp_inc;
  assign w_ram_rd  = r_mem[w_rd_addr];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op    <= OP_NONE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_sp    <= SP_TOP;
      r_err   <= 1'b0;
      r_rd    <= '0;
      r_flags <= '0;
    end else if (r_state != S_BUSY) begin
      if (w_req) begin
        r_op   <= w_op;
        r_cnt  <= 4'(MEM_LATENCY - 1);
        r_addr <= i_address[ADDR_W-1:0];
        r_data <= i_write_data;
      end
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      if (r_op == OP_PUSH) begin
        if (w_push_ok) r_sp  <= r_sp - 1'b1;
        else           r_err <= 1'b1;
      end
      if (r_op == OP_LOAD) r_rd <= w_ram_rd;
      if (w_pop) begin
        if (w_pop_ok) begin
          r_sp <= w_sp_inc;
          r_rd <= w_ram_rd;
          if (r_op == OP_POPF) r_flags <= w_ram_rd[2:0];
        end else begin
          r_err <= 1'b1;
          r_rd  <= '0;
        end
      end
    end
  end

  // RAM is not reset; a reset during the access cycle cancels the write.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_access) begin
      if (r_op == OP_STORE) r_mem[r_addr] <= r_data;
      else if (w_push_ok)   r_mem[r_sp]   <= r_data;
    end
  end

`ifdef MEM_LOAD_FWD_EN
  logic [15:0]       r_fwd_data;
  logic              r_fwd_valid;
  logic [ADDR_W-1:0] r_fwd_addr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fwd_data  <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
    end else if (w_access) begin
      if (r_op == OP_LOAD || w_pop) begin
        r_fwd_data  <= (r_op == OP_LOAD || w_pop_ok) ? w_ram_rd : 16'd0;
        r_fwd_valid <= 1'b1;
        r_fwd_addr  <= w_rd_addr;
      end else if (r_op == OP_STORE && r_addr == r_fwd_addr) begin
        r_fwd_valid <= 1'b0;
      end
    end
  end

  assign o_load_fwd_data  = r_fwd_data;
  assign o_load_fwd_valid = r_fwd_valid;
`else
  assign o_load_fwd_data  = 16'd0;
  assign o_load_fwd_valid = 1'b0;
`endif

  assign o_read_data     = r_rd;
  assign o_flags_restore = r_flags;
  assign o_sp            = r_sp;
  assign o_stack_err     = r_err;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: requests push expected results into a queue, a negedge monitor pops on data_valid.
module tb_memory_stage;

  localparam int K_STORE = 0, K_LOAD = 1, K_PUSH = 2, K_POP = 3, K_POPF = 4, K_BOTH = 5;

  typedef struct {
    int          kind;
    logic [15:0] rd;
    logic [2:0]  fl;
    logic [7:0]  sp;
    logic        err;
  } exp_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [1:0]  stack_op = 2'd0;
  logic [15:0] address = '0, write_data = '0;
  logic [15:0] read_data, load_fwd_data;
  logic [2:0]  flags_restore;
  logic        data_valid, stall, stack_err, load_fwd_valid;
  logic [7:0]  sp;

  int   checks = 0, errors = 0;
  exp_t q[$];

  memory_stage dut (
    .i_clk(clk), .i_reset(reset), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_stack_op(stack_op), .i_address(address), .i_write_data(write_data),
    .o_read_data(read_data), .o_flags_restore(flags_restore), .o_data_valid(data_valid),
    .o_stall(stall), .o_sp(sp), .o_stack_err(stack_err),
    .o_load_fwd_data(load_fwd_data), .o_load_fwd_valid(load_fwd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every data_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && data_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_data_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("read_data", 32'(read_data), 32'(e.rd));
        chk("flags_restore", 32'(flags_restore), 32'(e.fl));
        chk("sp", 32'(sp), 32'(e.sp));
        chk("stack_err", 32'(stack_err), 32'(e.err));
`ifdef MEM_LOAD_FWD_EN
        if (e.kind == K_LOAD || e.kind == K_POP || e.kind == K_POPF)
          chk("load_fwd", {15'd0, load_fwd_valid, load_fwd_data}, {15'd0, 1'b1, e.rd});
`else
        chk("load_fwd", {15'd0, load_fwd_valid, load_fwd_data}, 32'd0);
`endif
      end
    end
  end

  task automatic drive(input int k, input logic [15:0] a, input logic [15:0] wd);
    mem_write  = (k == K_STORE || k == K_BOTH);
    mem_read   = (k == K_LOAD || k == K_BOTH);
    stack_op   = (k == K_PUSH) ? 2'd1 : (k == K_POP) ? 2'd2 : (k == K_POPF) ? 2'd3 : 2'd0;
    address    = a;
    write_data = wd;
  endtask

  task automatic idle_inputs();
    mem_write = 1'b0; mem_read = 1'b0; stack_op = 2'd0;
  endtask

  // One request; req is dropped after the accept edge, so exactly 3 stall cycles are expected.
  task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] rd, input logic [2:0] fl, input logic [7:0] spv,
                       input logic err);
    exp_t e;
    int   st_cnt;
    bit   seen;
    e.kind = k; e.rd = rd; e.fl = fl; e.sp = spv; e.err = err;
    q.push_back(e);
    @(posedge clk); #1;
    drive(k, a, wd);
    st_cnt = 0;
    seen   = 0;
    @(negedge clk);
    if (stall) st_cnt++;
    @(posedge clk); #1;
    idle_inputs();
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (stall) st_cnt++;
      if (data_valid) seen = 1;
    end
    chk("data_valid_seen", 32'(seen), 32'd1);
    chk("stall_cycles", st_cnt, 32'd3);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_sp", 32'(sp), 32'hFF);
    chk("rst_err", 32'(stack_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_rd", 32'(read_data), 32'd0);
    chk("rst_fl", 32'(flags_restore), 32'd0);
    chk("rst_fwd", {15'd0, load_fwd_valid, load_fwd_data}, 32'd0);

    do_op(K_STORE, 16'h0012, 16'hBEEF, 16'h0000, 3'd0, 8'hFF, 1'b0);
    do_op(K_LOAD,  16'h0012, 16'h0000, 16'hBEEF, 3'd0, 8'hFF, 1'b0);

    do_op(K_BOTH,  16'h0003, 16'h00AA, 16'hBEEF, 3'd0, 8'hFF, 1'b0);
    do_op(K_LOAD,  16'h0003, 16'h0000, 16'h00AA, 3'd0, 8'hFF, 1'b0);

    // Reset in the first BUSY cycle of a store to 0x40 must cancel it.
    do_op(K_STORE, 16'h0040, 16'h1111, 16'h00AA, 3'd0, 8'hFF, 1'b0);
    @(posedge clk); #1;
    drive(K_STORE, 16'h0040, 16'h2222);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_dv", 32'(data_valid), 32'd0);
    chk("abort_rd", 32'(read_data), 32'd0);
    chk("abort_fwd_valid", 32'(load_fwd_valid), 32'd0);
    repeat (4) @(negedge clk);
    do_op(K_LOAD,  16'h0040, 16'h0000, 16'h1111, 3'd0, 8'hFF, 1'b0);

    do_op(K_STORE, 16'h0000, 16'h5A5A, 16'h1111, 3'd0, 8'hFF, 1'b0);

    do_op(K_PUSH,  16'h0000, 16'h1234, 16'h1111, 3'd0, 8'hFE, 1'b0);
    do_op(K_PUSH,  16'h0000, 16'h0005, 16'h1111, 3'd0, 8'hFD, 1'b0);
    do_op(K_POPF,  16'h0000, 16'h0000, 16'h0005, 3'b101, 8'hFE, 1'b0);
    do_op(K_POP,   16'h0000, 16'h0000, 16'h1234, 3'b101, 8'hFF, 1'b0);

    do_op(K_POP,   16'h0000, 16'h0000, 16'h0000, 3'b101, 8'hFF, 1'b1);
    for (int i = 0; i < 255; i++)
      do_op(K_PUSH, 16'h0000, 16'h0100 + 16'(i), 16'h0000, 3'b101, 8'(8'hFE - i), 1'b1);
    do_op(K_PUSH,  16'h0000, 16'hDEAD, 16'h0000, 3'b101, 8'h00, 1'b1);
    do_op(K_LOAD,  16'h0000, 16'h0000, 16'h5A5A, 3'b101, 8'h00, 1'b1);
    do_op(K_LOAD,  16'hFF12, 16'h0000, 16'h01ED, 3'b101, 8'h00, 1'b1);
    do_op(K_POPF,  16'h0000, 16'h0000, 16'h01FE, 3'b110, 8'h01, 1'b1);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
